// File: rtl/mem_bus_interface.sv
// mem_bus_interface: owns MAR/MDR and converts control-unit strobes into
// handshaked RAM transactions with wait-state support, a stall back to the
// control unit, and a sticky timeout error.
module mem_bus_interface #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  MDRread,
    input  logic                  RAMwrite,
    output logic [ADDR_WIDTH-1:0] MAR_q,
    output logic [DATA_WIDTH-1:0] MDR_q,
    output logic                  Stall,
    output logic                  bus_error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    // Counter only has to reach TIMEOUT-1, so log2 bits are enough.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          rd_prev_q;
    logic          wr_prev_q;

    logic rd_lvl;
    logic rd_start;
    logic wr_start;
    logic mdr_bus_load;

    // Rising-edge detection so a held strobe launches only one access.
    assign rd_lvl       = MDRin & MDRread;
    assign rd_start     = rd_lvl & ~rd_prev_q;
    assign wr_start     = RAMwrite & ~wr_prev_q;
    assign mdr_bus_load = MDRin & ~MDRread;

    // Control unit must hold while any access is outstanding.
    assign Stall = (state_q != IDLE);

    // Single FSM: MAR/MDR registers, request outputs, timeout and error flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
            MAR_q     <= '0;
            MDR_q     <= '0;
            bus_error <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // Edge-detect history tracks the strobes in every state, so a
            // start dropped while busy is not replayed later.
            rd_prev_q <= rd_lvl;
            wr_prev_q <= RAMwrite;

            // MAR is free to change mid-access; mem_addr holds the latched copy.
            if (MARin) begin
                MAR_q <= BusMuxOut[ADDR_WIDTH-1:0];
            end

            case (state_q)
                IDLE: begin
                    // Read has priority when both strobes rise together.
                    if (rd_start) begin
                        state_q  <= RD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= MAR_q;
                        cnt_q    <= '0;
                    end else if (wr_start) begin
                        state_q   <= WR;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= MAR_q;
                        mem_wdata <= MDR_q;
                        cnt_q     <= '0;
                    end
                    // Plain bus load of MDR; not a memory access.
                    if (mdr_bus_load) begin
                        MDR_q <= BusMuxOut;
                    end
                end

                RD: begin
                    if (mem_ack) begin
                        MDR_q   <= mem_rdata;
                        mem_req <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    mem_req <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed self-checking bench for mem_bus_interface.
module tb_mem_bus_interface;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [DW-1:0] BusMuxOut;
    logic          MARin, MDRin, MDRread, RAMwrite;
    logic [AW-1:0] MAR_q;
    logic [DW-1:0] MDR_q;
    logic          Stall, bus_error, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int checks = 0;
    int errors = 0;

    mem_bus_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread), .RAMwrite(RAMwrite),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .Stall(Stall), .bus_error(bus_error),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 Clock = ~Clock;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_mar(input logic [DW-1:0] v);
        MARin = 1'b1; BusMuxOut = v; tick(); MARin = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; tick(); tick(); Reset = 1'b0;
        checks++; if (MAR_q !== 9'h000) begin errors++; $display("FAIL reset_mar got=%h exp=000", MAR_q); end
        checks++; if (MDR_q !== 32'h0) begin errors++; $display("FAIL reset_mdr got=%h exp=0", MDR_q); end
        checks++; if ({Stall, bus_error, mem_req, mem_we} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got=%b exp=0000", {Stall, bus_error, mem_req, mem_we}); end
        checks++; if (mem_addr !== 9'h000 || mem_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_membus got=%h/%h exp=000/0", mem_addr, mem_wdata); end
    endtask

    task automatic test_mar_mdr_load();
        load_mar(32'h0000_0055);
        checks++; if (MAR_q !== 9'h055) begin errors++; $display("FAIL mar_load got=%h exp=055", MAR_q); end
        MDRin = 1'b1; MDRread = 1'b0; BusMuxOut = 32'h1234_5678; tick(); MDRin = 1'b0;
        checks++; if (MDR_q !== 32'h1234_5678) begin errors++; $display("FAIL mdr_bus_load got=%h exp=12345678", MDR_q); end
        checks++; if (Stall !== 1'b0 || mem_req !== 1'b0) begin errors++;
            $display("FAIL mdr_bus_nostall got=%b%b exp=00", Stall, mem_req); end
    endtask

    task automatic test_read_wait();
        load_mar(32'h0000_0010);
        // Ack while idle must not touch MDR or start anything.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; tick(); mem_ack = 1'b0;
        checks++; if (MDR_q !== 32'h1234_5678 || mem_req !== 1'b0) begin errors++;
            $display("FAIL idle_ack got=%h/%b exp=12345678/0", MDR_q, mem_req); end
        MDRin = 1'b1; MDRread = 1'b1; tick(); MDRin = 1'b0; MDRread = 1'b0;
        checks++; if (mem_addr !== 9'h010 || mem_we !== 1'b0) begin errors++;
            $display("FAIL rd_addr_we got=%h/%b exp=010/0", mem_addr, mem_we); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || Stall !== 1'b1) begin errors++;
                $display("FAIL rd_wait_cycle%0d got=%b%b exp=11", i, mem_req, Stall); end
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; end
            tick();
            mem_ack = 1'b0;
        end
        checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin errors++;
            $display("FAIL rd_done got=%b%b exp=00", mem_req, Stall); end
        checks++; if (MDR_q !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_data got=%h exp=cafef00d", MDR_q); end
    endtask

    task automatic test_write_held();
        MDRin = 1'b1; MDRread = 1'b0; BusMuxOut = 32'hA5A5_A5A5; tick(); MDRin = 1'b0;
        load_mar(32'h0000_01FF);
        RAMwrite = 1'b1; tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || Stall !== 1'b1) begin errors++;
            $display("FAIL wr_req got=%b%b%b exp=111", mem_req, mem_we, Stall); end
        checks++; if (mem_addr !== 9'h1FF || mem_wdata !== 32'hA5A5_A5A5) begin errors++;
            $display("FAIL wr_bus got=%h/%h exp=1ff/a5a5a5a5", mem_addr, mem_wdata); end
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ack = 1'b0;
        checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin errors++;
            $display("FAIL wr_done got=%b%b exp=00", mem_req, Stall); end
        // RAMwrite still held for cycles 3 and 4: no second request.
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_single_req c%0d got=%b exp=0", i, mem_req); end
        end
        RAMwrite = 1'b0;
        checks++; if (MDR_q !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wr_mdr_kept got=%h exp=a5a5a5a5", MDR_q); end
    endtask

    task automatic test_timeout();
        int n;
        MDRin = 1'b1; MDRread = 1'b1; tick(); MDRin = 1'b0; MDRread = 1'b0;
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_err_early got=%b exp=0", bus_error); end
        // Bus load during a read must be ignored.
        MDRin = 1'b1; BusMuxOut = 32'h7777_7777;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++; tick(); MDRin = 1'b0;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL to_req_cycles got=%0d exp=16", n); end
        checks++; if (bus_error !== 1'b1 || Stall !== 1'b0) begin errors++;
            $display("FAIL to_err got=%b/%b exp=1/0", bus_error, Stall); end
        checks++; if (MDR_q !== 32'hA5A5_A5A5) begin errors++; $display("FAIL to_mdr_kept got=%h exp=a5a5a5a5", MDR_q); end
        MDRin = 1'b1; MDRread = 1'b1; tick(); MDRin = 1'b0; MDRread = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222; tick(); mem_ack = 1'b0;
        checks++; if (MDR_q !== 32'h1111_2222 || mem_req !== 1'b0) begin errors++;
            $display("FAIL to_recover got=%h/%b exp=11112222/0", MDR_q, mem_req); end
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", bus_error); end
    endtask

    task automatic test_simultaneous();
        load_mar(32'h0000_0020);
        MDRin = 1'b1; MDRread = 1'b1; RAMwrite = 1'b1; tick();
        MDRin = 1'b0; MDRread = 1'b0; RAMwrite = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h020) begin errors++;
            $display("FAIL sim_read_wins got=%b%b/%h exp=10/020", mem_req, mem_we, mem_addr); end
        load_mar(32'h0000_00AA);
        checks++; if (MAR_q !== 9'h0AA || mem_addr !== 9'h020 || mem_req !== 1'b1) begin errors++;
            $display("FAIL sim_mar_mid got=%h/%h/%b exp=0aa/020/1", MAR_q, mem_addr, mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE; tick(); mem_ack = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || MDR_q !== 32'h0BAD_CAFE) begin errors++;
            $display("FAIL sim_no_write got=%b%b/%h exp=00/0badcafe", mem_req, mem_we, MDR_q); end
    endtask

    task automatic test_reset_mid();
        MDRin = 1'b1; MDRread = 1'b1; tick(); MDRin = 1'b0; MDRread = 1'b0;
        tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        checks++; if (mem_req !== 1'b0 || Stall !== 1'b0 || bus_error !== 1'b0) begin errors++;
            $display("FAIL rst_mid_flags got=%b%b%b exp=000", mem_req, Stall, bus_error); end
        checks++; if (MAR_q !== 9'h000 || MDR_q !== 32'h0) begin errors++;
            $display("FAIL rst_mid_regs got=%h/%h exp=000/0", MAR_q, MDR_q); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; tick(); mem_ack = 1'b0;
        checks++; if (MDR_q !== 32'h0 || mem_req !== 1'b0 || Stall !== 1'b0) begin errors++;
            $display("FAIL rst_late_ack got=%h/%b%b exp=0/00", MDR_q, mem_req, Stall); end
    endtask

    initial begin
        Reset = 1'b1; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; MDRread = 1'b0;
        RAMwrite = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        test_reset();
        test_mar_mdr_load();
        test_read_wait();
        test_write_held();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_interface.md
Name: mem_bus_interface

Overview:
- Memory-side datapath stage directly downstream of the control unit. It owns MAR and MDR and turns the control unit's MARin / MDRin / MDRread / RAMwrite strobes into handshaked transactions to a RAM that may insert wait states.
- It returns Stall so the control unit holds its current state until the access finishes, and bus_error if the RAM never acknowledges.

Parameters:
- ADDR_WIDTH, 9, width of MAR and mem_addr.
- DATA_WIDTH, 32, width of the data bus, MDR and memory data.
- TIMEOUT, 16, maximum mem_req cycles without mem_ack before the access is aborted; must be >= 2.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- BusMuxOut  in  DATA_WIDTH  internal data bus.
- MARin  in  1  load MAR from BusMuxOut[ADDR_WIDTH-1:0].
- MDRin  in  1  load MDR (source chosen by MDRread).
- MDRread  in  1  with MDRin: MDR source is memory, which starts a read.
- RAMwrite  in  1  write MDR to memory at MAR.
- MAR_q  out  ADDR_WIDTH  current MAR.
- MDR_q  out  DATA_WIDTH  current MDR (feeds the bus via MDRout).
- Stall  out  1  transaction in progress; the control unit must not advance.
- bus_error  out  1  sticky timeout flag.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  address latched at request.
- mem_wdata  out  DATA_WIDTH  write data latched at request.
- mem_rdata  in  DATA_WIDTH  read data; valid when mem_ack = 1.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Single clock; reset is synchronous and active-high. Reset has priority over every other input at the same edge.
- Reset values: MAR_q = 0, MDR_q = 0, state = IDLE, Stall = 0, bus_error = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, timeout counter = 0, edge-detect registers = 0.
- Reset during a transaction: the transaction is abandoned. mem_req is 0 after that edge and a late mem_ack is ignored.
- Command detection:
  - rd_start = MDRin & MDRread & ~prev(MDRin & MDRread).
  - wr_start = RAMwrite & ~prev(RAMwrite).
  - A level held across several cycles therefore starts exactly one transaction.
- Commands are accepted only in IDLE. Starts detected in RD or WR are dropped; their prev registers still update.
- If rd_start and wr_start occur at the same edge, the read wins and the write is dropped.
- MAR: loads whenever MARin = 1, in any state. This does not disturb an in-flight access, because mem_addr was latched at request.
- MDR bus load: MDRin & ~MDRread loads BusMuxOut in IDLE only; it is ignored in RD and WR. This is a plain register load with no Stall.
- States:
  - IDLE:
    - on rd_start -> RD; mem_req = 1, mem_we = 0, mem_addr = MAR_q.
    - on wr_start -> WR; mem_req = 1, mem_we = 1, mem_addr = MAR_q, mem_wdata = MDR_q.
    - The timeout counter is cleared on either start.
  - RD:
    - if mem_ack: MDR_q <= mem_rdata, mem_req <= 0, go to IDLE.
    - else if counter == TIMEOUT-1: mem_req <= 0, bus_error <= 1, MDR unchanged, go to IDLE.
    - else counter + 1.
  - WR: same as RD, but on mem_ack MDR_q is not changed.
- Stall = (state != IDLE), decoded from registered state.
  - A start seen at edge N raises Stall and mem_req after edge N.
  - mem_ack sampled at edge N+k drops both after edge N+k.
  - Minimum Stall duration is 1 cycle (mem_ack in the first request cycle).
- mem_ack while in IDLE is ignored.
- bus_error is sticky: only Reset clears it. It does not block later transactions.
- mem_addr and mem_wdata hold their last values after completion.

Test Plan:
- Reset, then MARin with BusMuxOut = 0x00000055 -> MAR_q = 0x055. Then MDRin = 1, MDRread = 0, BusMuxOut = 0x12345678 -> MDR_q = 0x12345678, Stall stays 0.
- Read with a 3-cycle memory delay: MAR = 0x010, MDRin = MDRread = 1 for 1 cycle, mem_ack in the 3rd request cycle with mem_rdata = 0xCAFEF00D -> mem_req = 1 and Stall = 1 for exactly 3 cycles, mem_addr = 0x010, mem_we = 0, then MDR_q = 0xCAFEF00D.
- Write: MDR = 0xA5A5A5A5, MAR = 0x1FF, RAMwrite held high for 4 cycles, mem_ack in the 1st cycle -> exactly one request with mem_we = 1, mem_addr = 0x1FF, mem_wdata = 0xA5A5A5A5; Stall is high for 1 cycle.
- Timeout: read with mem_ack never asserted -> mem_req drops after exactly TIMEOUT = 16 cycles, bus_error = 1, MDR unchanged. A following read with prompt ack completes normally and bus_error stays 1.
- Simultaneous start: MDRin & MDRread and RAMwrite rise together -> a read is issued, no write occurs. Also, MARin = 1 with 0x0AA during the read -> mem_addr is unchanged and MAR_q = 0x0AA.
- Reset asserted in the 2nd cycle of a pending read -> after that edge: mem_req = 0, Stall = 0, MAR/MDR = 0. A mem_ack arriving next cycle has no effect.
